// File: rtl/sevseg_pkg.sv
// rtl/sevseg_pkg.sv - segment constants and helpers for the seven-segment scan driver
package sevseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b111_1111;
  localparam logic [6:0] SEG_DASH  = 7'b011_1111;

  // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 renders as a dash.
  function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'd0:    seg = 7'b100_0000;
      4'd1:    seg = 7'b111_1001;
      4'd2:    seg = 7'b010_0100;
      4'd3:    seg = 7'b011_0000;
      4'd4:    seg = 7'b001_1001;
      4'd5:    seg = 7'b001_0010;
      4'd6:    seg = 7'b000_0010;
      4'd7:    seg = 7'b111_1000;
      4'd8:    seg = 7'b000_0000;
      4'd9:    seg = 7'b001_0000;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 32'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble converter, one input bit per clock
// Only the low DIGITS nibbles are kept; higher digits are dropped since overflow is decided elsewhere.
module bin2bcd_seq #(
  parameter int DATA_W = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam int BW = 4 * DIGITS;

  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [BW-1:0]     adj;
  logic [BW-1:0]     step;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    step = {adj[BW-2:0], sh_q[DATA_W-1]};
  end

  // done is combinational so the caller can commit step on the same edge busy drops.
  assign done   = busy_q && (cnt_q == CW'(1));
  assign busy   = busy_q;
  assign result = step;

  always_comb begin
    sh_d   = sh_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (busy_q) begin
      sh_d  = sh_q << 1;
      bcd_d = step;
      cnt_d = cnt_q - CW'(1);
      if (done) begin
        busy_d = 1'b0;
      end
    end
    if (start) begin
      sh_d   = bin;
      bcd_d  = '0;
      cnt_d  = CW'(DATA_W);
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/seven_segment_scan.sv
// rtl/seven_segment_scan.sv - multiplexed common-anode seven-segment driver with binary load
// SEVSEG_LZB_EN enables leading-zero blanking.
module seven_segment_scan
  import sevseg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int DATA_W   = 14,
  parameter int SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic [DIGITS-1:0] blank_mask,
  output logic              busy,
  output logic              overflow,
  output logic [DIGITS-1:0] DIGIT,
  output logic [6:0]        DISPLAY
);

  localparam int SCW = $clog2(SCAN_DIV);
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW  = 4 * DIGITS;
  localparam logic [SCW-1:0] DIV_MAX = SCW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]  IDX_MAX = IW'(DIGITS - 1);
  localparam logic [31:0]    LIMIT   = pow10(DIGITS) - 32'd1;

  logic           conv_busy;
  logic           conv_done;
  logic [BW-1:0]  conv_result;
  logic           accept;
  logic [31:0]    data_ext;

  logic           ovf_pend_q, ovf_pend_d;
  logic           ovf_q, ovf_d;
  logic [BW-1:0]  disp_q, disp_d;
  logic [SCW-1:0] scan_q, scan_d;
  logic [IW-1:0]  idx_q, idx_d;

  logic [BW-1:0]  shifted;
  logic [3:0]     nib;
  logic           lz_blank;

  // A load on the committing edge is accepted, giving back-to-back conversions.
  assign accept   = load && (!conv_busy || conv_done);
  assign data_ext = 32'(data);

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept),
    .bin    (data),
    .busy   (conv_busy),
    .done   (conv_done),
    .result (conv_result)
  );

  always_comb begin
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
    disp_d     = disp_q;
    scan_d     = scan_q + SCW'(1);
    idx_d      = idx_q;
    if (accept) begin
      ovf_pend_d = (data_ext > LIMIT);
    end
    if (conv_done) begin
      disp_d = conv_result;
      ovf_d  = ovf_pend_q;
    end
    if (scan_q == DIV_MAX) begin
      scan_d = '0;
      idx_d  = (idx_q == '0) ? IDX_MAX : idx_q - IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      disp_q     <= '0;
      scan_q     <= '0;
      idx_q      <= IDX_MAX;
    end else begin
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
      disp_q     <= disp_d;
      scan_q     <= scan_d;
      idx_q      <= idx_d;
    end
  end

  // Nibbles at and above the active index; all-zero means the digit is a leading zero.
  always_comb begin
    shifted = disp_q >> {idx_q, 2'b00};
    nib     = shifted[3:0];
`ifdef SEVSEG_LZB_EN
    lz_blank = (idx_q != '0) && (shifted == '0);
`else
    lz_blank = 1'b0;
`endif
  end

  always_comb begin
    DIGIT = ~(DIGITS'(1) << idx_q);
    if (blank_mask[idx_q]) begin
      DISPLAY = SEG_BLANK;
    end else if (ovf_q) begin
      DISPLAY = SEG_DASH;
    end else if (lz_blank) begin
      DISPLAY = SEG_BLANK;
    end else begin
      DISPLAY = seg_encode(nib);
    end
  end

  assign busy     = conv_busy;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// tb/tb_seven_segment_scan.sv - directed self-checking bench for seven_segment_scan
module tb_seven_segment_scan;

  localparam int DIGITS   = 4;
  localparam int DATA_W   = 14;
  localparam int SCAN_DIV = 4;

`ifdef SEVSEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  localparam logic [6:0] S0 = 7'b100_0000, S1 = 7'b111_1001, S2 = 7'b010_0100;
  localparam logic [6:0] S3 = 7'b011_0000, S4 = 7'b001_1001, S5 = 7'b001_0010;
  localparam logic [6:0] S6 = 7'b000_0010, S7 = 7'b111_1000, S8 = 7'b000_0000;
  localparam logic [6:0] S9 = 7'b001_0000, SB = 7'b111_1111, SD = 7'b011_1111;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load = 1'b0;
  logic [DATA_W-1:0] data = '0;
  logic [DIGITS-1:0] blank_mask = '0;
  logic              busy;
  logic              overflow;
  logic [DIGITS-1:0] DIGIT;
  logic [6:0]        DISPLAY;

  int checks = 0;
  int passed = 0;

  logic [3:0] obs_dig[4];
  logic [6:0] obs_seg[4];
  bit         scan_ok;

  seven_segment_scan #(
    .DIGITS   (DIGITS),
    .DATA_W   (DATA_W),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .data       (data),
    .blank_mask (blank_mask),
    .busy       (busy),
    .overflow   (overflow),
    .DIGIT      (DIGIT),
    .DISPLAY    (DISPLAY)
  );

  always #5 clk = ~clk;

  task automatic pulse_load(input logic [DATA_W-1:0] v);
    @(negedge clk);
    data = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Records one full left-to-right scan starting at the first cycle of the leftmost digit.
  task automatic capture_scan();
    int n;
    n = 0;
    scan_ok = 1'b0;
    while (DIGIT == 4'b0111 && n < 50) begin @(negedge clk); n++; end
    while (DIGIT != 4'b0111 && n < 50) begin @(negedge clk); n++; end
    if (n < 50) scan_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      obs_dig[i] = DIGIT;
      obs_seg[i] = DISPLAY;
      repeat (SCAN_DIV) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [6:0] exp_left;
    exp_left = LZB ? SB : S0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow); else passed++;
    checks++; if (DIGIT !== 4'b0111) $display("FAIL reset_digit got %b want 0111", DIGIT); else passed++;
    checks++; if (DISPLAY !== exp_left) $display("FAIL reset_display got %b want %b", DISPLAY, exp_left); else passed++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (DIGIT !== 4'b0111) $display("FAIL prescale_hold got %b want 0111", DIGIT); else passed++;
    @(negedge clk);
    checks++; if (DIGIT !== 4'b1011) $display("FAIL prescale_wrap got %b want 1011", DIGIT); else passed++;
  endtask

  task automatic test_load_1234();
    int n;
    logic [6:0] exp[4];
    logic [3:0] ed;
    exp = '{S1, S2, S3, S4};
    pulse_load(14'd1234);
    wait_idle(n);
    checks++; if (n !== 14) $display("FAIL busy_len_1234 got %0d want 14", n); else passed++;
    capture_scan();
    checks++; if (!scan_ok) $display("FAIL scan_sync_1234 got timeout want leftmost"); else passed++;
    for (int i = 0; i < 4; i++) begin
      ed = 4'b1000;
      ed = ~(ed >> i);
      checks++; if (obs_dig[i] !== ed) $display("FAIL digit_1234[%0d] got %b want %b", i, obs_dig[i], ed); else passed++;
      checks++; if (obs_seg[i] !== exp[i]) $display("FAIL seg_1234[%0d] got %b want %b", i, obs_seg[i], exp[i]); else passed++;
    end
  endtask

  task automatic test_load_while_busy();
    int n;
    logic [6:0] exp[4];
    exp = LZB ? '{SB, SB, S4, S2} : '{S0, S0, S4, S2};
    pulse_load(14'd42);
    repeat (2) @(negedge clk);
    data = 14'd9999;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_idle(n);
    checks++; if (n !== 11) $display("FAIL busy_ignored_load got %0d want 11", n); else passed++;
    capture_scan();
    for (int i = 0; i < 4; i++) begin
      checks++; if (obs_seg[i] !== exp[i]) $display("FAIL seg_42[%0d] got %b want %b", i, obs_seg[i], exp[i]); else passed++;
    end
  endtask

  task automatic test_overflow();
    int n;
    logic [6:0] exp[4];
    pulse_load(14'd9999);
    wait_idle(n);
    checks++; if (overflow !== 1'b0) $display("FAIL ovf_9999 got %b want 0", overflow); else passed++;
    capture_scan();
    for (int i = 0; i < 4; i++) begin
      checks++; if (obs_seg[i] !== S9) $display("FAIL seg_9999[%0d] got %b want %b", i, obs_seg[i], S9); else passed++;
    end
    pulse_load(14'd10000);
    wait_idle(n);
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_10000 got %b want 1", overflow); else passed++;
    capture_scan();
    for (int i = 0; i < 4; i++) begin
      checks++; if (obs_seg[i] !== SD) $display("FAIL seg_dash[%0d] got %b want %b", i, obs_seg[i], SD); else passed++;
    end
    pulse_load(14'd7);
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_hold_midconv got %b want 1", overflow); else passed++;
    checks++; if (DISPLAY !== SD) $display("FAIL display_hold_midconv got %b want %b", DISPLAY, SD); else passed++;
    wait_idle(n);
    checks++; if (overflow !== 1'b0) $display("FAIL ovf_7 got %b want 0", overflow); else passed++;
    exp = LZB ? '{SB, SB, SB, S7} : '{S0, S0, S0, S7};
    capture_scan();
    for (int i = 0; i < 4; i++) begin
      checks++; if (obs_seg[i] !== exp[i]) $display("FAIL seg_7[%0d] got %b want %b", i, obs_seg[i], exp[i]); else passed++;
    end
  endtask

  task automatic test_leading_zeros();
    int n;
    logic [6:0] exp[4];
    pulse_load(14'd0);
    wait_idle(n);
    exp = LZB ? '{SB, SB, SB, S0} : '{S0, S0, S0, S0};
    capture_scan();
    for (int i = 0; i < 4; i++) begin
      checks++; if (obs_seg[i] !== exp[i]) $display("FAIL seg_0[%0d] got %b want %b", i, obs_seg[i], exp[i]); else passed++;
    end
    pulse_load(14'd305);
    wait_idle(n);
    exp = LZB ? '{SB, S3, S0, S5} : '{S0, S3, S0, S5};
    capture_scan();
    for (int i = 0; i < 4; i++) begin
      checks++; if (obs_seg[i] !== exp[i]) $display("FAIL seg_305[%0d] got %b want %b", i, obs_seg[i], exp[i]); else passed++;
    end
  endtask

  task automatic test_blank_mask();
    int n;
    logic [6:0] exp[4];
    exp = '{S5, S6, SB, S8};
    blank_mask = 4'b0010;
    pulse_load(14'd5678);
    wait_idle(n);
    capture_scan();
    for (int i = 0; i < 4; i++) begin
      checks++; if (obs_seg[i] !== exp[i]) $display("FAIL seg_mask[%0d] got %b want %b", i, obs_seg[i], exp[i]); else passed++;
    end
    blank_mask = 4'b0000;
  endtask

  task automatic test_back_to_back();
    int n;
    logic [6:0] exp[4];
    exp = '{S2, S0, S2, S4};
    pulse_load(14'd99);
    repeat (13) @(negedge clk);
    data = 14'd2024;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checks++; if (busy !== 1'b1) $display("FAIL b2b_accept got %b want 1", busy); else passed++;
    wait_idle(n);
    checks++; if (n !== 14) $display("FAIL b2b_busy_len got %0d want 14", n); else passed++;
    capture_scan();
    for (int i = 0; i < 4; i++) begin
      checks++; if (obs_seg[i] !== exp[i]) $display("FAIL seg_2024[%0d] got %b want %b", i, obs_seg[i], exp[i]); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [6:0] exp_left;
    exp_left = LZB ? SB : S0;
    pulse_load(14'd8888);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL midrst_ovf got %b want 0", overflow); else passed++;
    checks++; if (DIGIT !== 4'b0111) $display("FAIL midrst_digit got %b want 0111", DIGIT); else passed++;
    checks++; if (DISPLAY !== exp_left) $display("FAIL midrst_display got %b want %b", DISPLAY, exp_left); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    pulse_load(14'd8888);
    wait_idle(n);
    checks++; if (n !== 14) $display("FAIL postrst_busy_len got %0d want 14", n); else passed++;
    capture_scan();
    for (int i = 0; i < 4; i++) begin
      checks++; if (obs_seg[i] !== S8) $display("FAIL seg_8888[%0d] got %b want %b", i, obs_seg[i], S8); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_load_1234();
    test_load_while_busy();
    test_overflow();
    test_leading_zeros();
    test_blank_mask();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan.md
Name: seven_segment_scan

Overview:
- Parametrised successor to the team's 4-digit multiplexed seven-segment driver.
- Accepts a binary value through a load handshake and converts it to BCD sequentially (shift-add-3, one bit per clock).
- Scans DIGITS common-anode digits using an internal scan prescaler, so no divided clock is needed.
- Adds overflow indication and per-digit blanking; sits between application counters and the board's DIGIT/DISPLAY pins.

Parameters:
- DIGITS, 4: number of multiplexed digits (1..8).
- DATA_W, 14: width of the binary input (1..27).
- SCAN_DIV, 100000: clk cycles each digit stays active (>=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  request to capture data. Honoured only when busy=0.
- data  in  DATA_W  unsigned binary value to display.
- blank_mask  in  DIGITS  bit i=1 forces digit i blank. Bit DIGITS-1 is the leftmost digit.
- busy  out  1  conversion in progress.
- overflow  out  1  captured value exceeds 10^DIGITS-1.
- DIGIT  out  DIGITS  active-low digit enables, one-hot-low.
- DISPLAY  out  7  active-low segments {g,f,e,d,c,b,a}.

Behaviour:
- Reset (async, rst_n=0):
  - busy=0, overflow=0, scan counter=0, digit index=DIGITS-1 (leftmost).
  - DIGIT has only its MSB low.
  - Displayed BCD register = all zeros.
- Load and conversion timing:
  - load=1 with busy=0 at edge t captures data; busy=1 from t.
  - Conversion runs DATA_W iterations, one per clock. Each iteration adds 3 to every BCD nibble >=5, then shifts left by one with the next data MSB.
  - At edge t+DATA_W: the displayed BCD register and overflow update atomically, and busy returns to 0.
  - A load at edge t+DATA_W is accepted, giving back-to-back conversions.
- load while busy=1 is ignored. No queuing, no error flag.
- Displayed value stays at the previous conversion result until the new one commits. There is never a partial update.
- Overflow:
  - overflow=1 iff the captured data > 10^DIGITS-1. Compare on capture and commit together with the BCD result.
  - While overflow=1, every non-masked digit shows a dash (011_1111).
  - The internal BCD register needs DIGITS+1 nibbles, or truncate, since the compare is authoritative.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1.
  - On its wrap, the digit index decrements (DIGITS-1 → 0 → DIGITS-1).
  - DIGIT and DISPLAY are combinational from the registered index and the displayed BCD. Both change on the same edge, so there is no ghosting cycle.
- Segment codes:
  - 0=100_0000, 1=111_1001, 2=010_0100, 3=011_0000, 4=001_1001
  - 5=001_0010, 6=000_0010, 7=111_1000, 8=000_0000, 9=001_0000
  - blank=111_1111, dash=011_1111
- Output priority: blank_mask > overflow dash > leading-zero blank (optional feature) > digit code.
- rst_n asserted mid-conversion aborts it. The display returns to zero and the pending value is discarded.
- DIGITS=1: DIGIT is constantly 0 and the index never changes.

Optional Feature:
- Macro SEVSEG_LZB_EN enables leading-zero blanking.
- Defined:
  - Nibbles to the left of the most significant non-zero nibble show blank.
  - Digit 0 (rightmost) is never LZB-blanked, so the value 0 shows a single "0".
  - Not applied while overflow=1.
- Undefined: all digits show their numeral, including leading zeros.

Decomposition:
- Package sevseg_pkg:
  - Segment constants SEG_BLANK and SEG_DASH.
  - Function seg_encode(nibble) returning DISPLAY for 0..9, SEG_DASH otherwise.
  - Function pow10(n) used for the overflow limit.
- One sub-module, bin2bcd_seq: the sequential double-dabble converter with start/busy/done and result ports, parametrised by DATA_W and DIGITS.
- Scan, blanking and muxing stay in the top level.

Test Plan:
- Reset, then load 1234 (DIGITS=4, SCAN_DIV=4):
  - busy is high for 14 cycles.
  - Digits scan left to right as 1,2,3,4 with DISPLAY 111_1001, 010_0100, 011_0000, 001_1001.
  - DIGIT sequence is 0111, 1011, 1101, 1110.
- Load 42, then assert load again 3 cycles later with 9999: the second load is ignored and the display shows 0042.
- Load 10000: overflow=1 and all digits show 011_1111. Then load 7: overflow=0 and the display shows 0007.
- With SEVSEG_LZB_EN:
  - Load 0 → DISPLAY is 111_1111 ×3 and then 100_0000.
  - Load 305 → blank,3,0,5.
- blank_mask=4'b0010 with value 5678: the second digit from the right is 111_1111, the others are 5,6,8.
- Pulse rst_n low at iteration 6 of converting 8888: outputs return to reset values and busy=0. A load immediately after reset converts correctly.
